// File: rtl/data_path_pkg.sv
// Shared widths and A-input select encodings for the accumulator datapath.
package data_path_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 32;
    localparam int OPC_W     = 3;

    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_RAM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_e;

endpackage

// File: rtl/datapath_ram.sv
// 32x8 unified program/data RAM: combinational read, synchronous write.
// Define DATAPATH_RAM_CLEAR_EN to have clear zero every word asynchronously.
module datapath_ram
    import data_path_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign rdata = mem[addr];

`ifdef DATAPATH_RAM_CLEAR_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end
`else
    // NOTE: the array is deliberately left out of reset so it maps onto plain
    // RAM; clear still has to gate the write enable.
    always_ff @(posedge clk) begin
        if (we && !clear) begin
            mem[addr] <= wdata;
        end
    end
`endif

endmodule

// File: rtl/data_path.sv
// Accumulator datapath: PC, IR, A, 32x8 RAM and adder/subtractor, steered by
// an external control FSM. RAM clearing is selected with DATAPATH_RAM_CLEAR_EN.
module data_path
    import data_path_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              IRload,
    input  logic              JMPmux,
    input  logic              PCload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic [1:0]        Asel,
    input  logic              Aload,
    input  logic              Sub,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic [OPC_W-1:0]  IR75,
    output logic              Aeq0,
    output logic              Apos,
    output logic [ADDR_W-1:0] MeminstOut,
    output logic [DATA_W-1:0] regAOut,
    output logic [DATA_W-1:0] RAMout,
    output logic [ADDR_W-1:0] IR40
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] acc_next;
    logic [ADDR_W-1:0] pc_next;

    assign MeminstOut = Meminst ? ir[ADDR_W-1:0] : pc;

    datapath_ram u_ram (
        .clk   (clk),
        .clear (clear),
        .we    (MemWr),
        .addr  (MeminstOut),
        .wdata (acc),
        .rdata (RAMout)
    );

    // Carry and borrow fall off the top: the accumulator wraps modulo 256.
    assign alu     = Sub ? (acc - RAMout) : (acc + RAMout);
    assign pc_next = JMPmux ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);

    // NOTE: every path assigns acc_next, so this mux stays purely combinational.
    always_comb begin
        acc_next = '0;
        unique case (asel_e'(Asel))
            ASEL_ALU:  acc_next = alu;
            ASEL_IN:   acc_next = in;
            ASEL_RAM:  acc_next = RAMout;
            ASEL_ZERO: acc_next = '0;
            default:   acc_next = '0;
        endcase
    end

    // NOTE: non-blocking updates let IR, PC and A all see the pre-edge values,
    // which is what makes fetch and store-while-load behave.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
        end else begin
            if (IRload) ir  <= RAMout;
            if (PCload) pc  <= pc_next;
            if (Aload)  acc <= acc_next;
        end
    end

    assign out     = acc;
    assign regAOut = acc;
    assign IR75    = ir[DATA_W-1:DATA_W-OPC_W];
    assign IR40    = ir[ADDR_W-1:0];
    assign Aeq0    = (acc == '0);
    assign Apos    = ~acc[DATA_W-1];

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: a register-level model compared every
// cycle, plus literal expectations along a directed instruction sequence.
module tb_data_path;
    import data_path_pkg::*;

    logic       clk;
    logic       clear;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
    logic [1:0] Asel;
    logic [7:0] in;
    logic [7:0] out, regAOut, RAMout;
    logic [2:0] IR75;
    logic [4:0] MeminstOut, IR40;
    logic       Aeq0, Apos;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    data_path dut (
        .clk        (clk),
        .clear      (clear),
        .IRload     (IRload),
        .JMPmux     (JMPmux),
        .PCload     (PCload),
        .Meminst    (Meminst),
        .MemWr      (MemWr),
        .Asel       (Asel),
        .Aload      (Aload),
        .Sub        (Sub),
        .in         (in),
        .out        (out),
        .IR75       (IR75),
        .Aeq0       (Aeq0),
        .Apos       (Apos),
        .MeminstOut (MeminstOut),
        .regAOut    (regAOut),
        .RAMout     (RAMout),
        .IR40       (IR40)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain integers and an array.
    int   m_pc, m_ir, m_a;
    int   m_mem [32];
    logic [31:0] m_vld = '0;

    function automatic int m_addr();
        return Meminst ? (m_ir % 32) : m_pc;
    endfunction

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_pc <= 0;
            m_ir <= 0;
            m_a  <= 0;
`ifdef DATAPATH_RAM_CLEAR_EN
            for (int i = 0; i < 32; i++) m_mem[i] <= 0;
            m_vld <= '1;
`endif
        end else begin
            if (IRload) m_ir <= m_mem[m_addr()];
            if (PCload) m_pc <= JMPmux ? (m_ir % 32) : (m_pc + 1) % 32;
            if (Aload) begin
                case (Asel)
                    2'b00:   m_a <= Sub ? (m_a - m_mem[m_addr()] + 256) % 256
                                        : (m_a + m_mem[m_addr()]) % 256;
                    2'b01:   m_a <= int'(in);
                    2'b10:   m_a <= m_mem[m_addr()];
                    default: m_a <= 0;
                endcase
            end
            if (MemWr) begin
                m_mem[m_addr()] <= m_a;
                m_vld[m_addr()] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out",        out,                8'(m_a));
            check("regAOut",    regAOut,            8'(m_a));
            check("IR75",       8'(IR75),           8'(m_ir / 32));
            check("IR40",       8'(IR40),           8'(m_ir % 32));
            check("MeminstOut", 8'(MeminstOut),     8'(m_addr()));
            check("Aeq0",       8'(Aeq0),           8'(m_a == 0));
            check("Apos",       8'(Apos),           8'(m_a < 128));
            if (m_vld[m_addr()])
                check("RAMout", RAMout,             8'(m_mem[m_addr()]));
        end
    end

    task automatic step(input logic irl, input logic jmp, input logic pcl, input logic mi,
                        input logic mw, input logic [1:0] as, input logic al,
                        input logic sb, input logic [7:0] d);
        IRload  = irl;
        JMPmux  = jmp;
        PCload  = pcl;
        Meminst = mi;
        MemWr   = mw;
        Asel    = as;
        Aload   = al;
        Sub     = sb;
        in      = d;
        @(posedge clk);
        #1;
        IRload = 1'b0;
        PCload = 1'b0;
        MemWr  = 1'b0;
        Aload  = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] d);
        step(0, 0, 0, Meminst, 0, ASEL_IN, 1, 0, d);
    endtask

    initial begin
        clear = 1'b0;
        IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
        Asel = 2'b00; Aload = 0; Sub = 0; in = 8'h00;

        // Mid-cycle asynchronous clear
        @(posedge clk);
        #3 clear = 1'b1;
        #1;
        check("rst_out",  out,              8'h00);
        check("rst_ir",   8'(IR40),         8'h00);
        check("rst_op",   8'(IR75),         8'h00);
        check("rst_addr", 8'(MeminstOut),   8'h00);
        check("rst_aeq0", 8'(Aeq0),         8'h01);
        check("rst_apos", 8'(Apos),         8'h01);
        cmp_en = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;

        // Input and store
        load_a(8'd3);
        check("load_a", out, 8'd3);
        step(0, 0, 0, 1, 1, ASEL_ALU, 0, 0, 0);
        check("store_mem0", RAMout, 8'd3);

        // Add and subtract through mem[0] at PC=0
        step(0, 0, 0, 0, 0, ASEL_ALU, 1, 0, 0);
        check("add_3p3", out, 8'd6);
        load_a(8'd3);
        step(0, 0, 0, 0, 0, ASEL_ALU, 1, 1, 0);
        check("sub_3m3", out, 8'd0);
        check("sub_aeq0", 8'(Aeq0), 8'h01);
        load_a(8'd1);
        step(0, 0, 0, 1, 1, ASEL_ALU, 0, 0, 0);
        step(0, 0, 0, 0, 0, ASEL_ZERO, 1, 0, 8'hAA);
        check("zero_a", out, 8'd0);
        step(0, 0, 0, 0, 0, ASEL_ALU, 1, 1, 0);
        check("sub_0m1", out, 8'hFF);
        check("sub_apos", 8'(Apos), 8'h00);

        // Restore mem[0]=3 and fetch
        load_a(8'd3);
        step(0, 0, 0, 1, 1, ASEL_ALU, 0, 0, 0);
        step(1, 0, 1, 0, 0, ASEL_ALU, 0, 0, 0);
        check("fetch_ir40", 8'(IR40), 8'd3);
        check("fetch_ir75", 8'(IR75), 8'd0);
        check("fetch_pc", 8'(MeminstOut), 8'd1);
        Meminst = 1'b1;
        #1 check("fetch_irad", 8'(MeminstOut), 8'd3);

        // Jump to IR[4:0]
        step(0, 1, 1, 0, 0, ASEL_ALU, 0, 0, 0);
        check("jump_pc3", 8'(MeminstOut), 8'd3);

        // mem[3]=1F, then IRload with jump on the same edge: PC takes old IR
        load_a(8'h1F);
        step(0, 0, 0, 1, 1, ASEL_ALU, 0, 0, 0);
        step(1, 1, 1, 1, 0, ASEL_ALU, 0, 0, 0);
        check("irjmp_ir", 8'(IR40), 8'h1F);
        Meminst = 1'b0;
        #1 check("irjmp_pc", 8'(MeminstOut), 8'd3);
        step(0, 1, 1, 0, 0, ASEL_ALU, 0, 0, 0);
        check("jump_pc31", 8'(MeminstOut), 8'd31);
        step(0, 0, 1, 0, 0, ASEL_ALU, 0, 0, 0);
        check("pc_wrap", 8'(MeminstOut), 8'd0);

        // Store-while-load at address 31
        Meminst = 1'b1;
        load_a(8'd5);
        step(0, 0, 0, 1, 1, ASEL_IN, 1, 0, 8'd9);
        check("coll_ram", RAMout, 8'd5);
        check("coll_a", out, 8'd9);

        // Write and IRload at the same address: IR gets pre-write data
        step(1, 0, 0, 1, 1, ASEL_ALU, 0, 0, 0);
        check("wr_ir_pre", 8'(IR40), 8'd5);
        Meminst = 1'b0;

        // MemWr held across a clear edge must not write
        load_a(8'd7);
        MemWr = 1'b1;
        #2 clear = 1'b1;
        #1 check("clr_mid_a", out, 8'h00);
        @(posedge clk);
        #1;
        MemWr = 1'b0;
        clear = 1'b0;
        #1;
`ifdef DATAPATH_RAM_CLEAR_EN
        check("clr_nowrite", RAMout, 8'd0);
`else
        check("clr_nowrite", RAMout, 8'd3);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
